// File: rtl/regfile_write_sequencer.sv
// Write-side sequencer for a latch-based register file.
// Accepts writes over WE/READY, holds one active and one pending request,
// and drives D plus a one-hot WEN/nWEN pulse with setup and hold margins.
// Optional macro WRITE_FORWARD_EN adds a combinational forwarding lookup
// (FWD_RADDR / FWD_HIT / FWD_DATA) over the pending and active slots.
module regfile_write_sequencer #(
  parameter int NREGS        = 32,
  parameter int AW           = 5,
  parameter int XLEN         = 32,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [XLEN-1:0]  WDATA,
  output logic             READY,
  output logic             BUSY,
  output logic [XLEN-1:0]  D,
  output logic [NREGS-1:0] WEN,
  output logic [NREGS-1:0] nWEN
`ifdef WRITE_FORWARD_EN
  ,
  input  logic [AW-1:0]    FWD_RADDR,
  output logic             FWD_HIT,
  output logic [XLEN-1:0]  FWD_DATA
`endif
);

  localparam int MAXC = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [AW-1:0]   act_addr, act_addr_n;
  logic [XLEN-1:0] act_data, act_data_n;
  logic            pend_valid, pend_valid_n;
  logic [AW-1:0]   pend_addr, pend_addr_n;
  logic [XLEN-1:0] pend_data, pend_data_n;
  logic [XLEN-1:0] d_n;
  logic [NREGS-1:0] wen_n;
  logic            accept, take;

  assign READY  = !pend_valid && !RST;
  assign BUSY   = (state != IDLE) || pend_valid;
  assign accept = WE && READY;
  // Row 0 and out-of-range rows complete the handshake but are never written.
  assign take   = accept && (WADDR != '0) && ({1'b0, WADDR} < NREGS_W);

  // State, slot and registered-output update
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      act_addr   <= '0;
      act_data   <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      D          <= '0;
      WEN        <= '0;
      nWEN       <= '1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      act_addr   <= act_addr_n;
      act_data   <= act_data_n;
      pend_valid <= pend_valid_n;
      pend_addr  <= pend_addr_n;
      pend_data  <= pend_data_n;
      D          <= d_n;
      WEN        <= wen_n;
      nWEN       <= ~wen_n;
    end
  end

  // Next-state and slot management
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    act_addr_n   = act_addr;
    act_data_n   = act_data;
    pend_valid_n = pend_valid;
    pend_addr_n  = pend_addr;
    pend_data_n  = pend_data;
    unique case (state)
      IDLE: begin
        if (take) begin
          act_addr_n = WADDR;
          act_data_n = WDATA;
          cnt_n      = CW'(SETUP_CYCLES - 1);
          state_n    = SETUP;
        end
      end
      SETUP: begin
        if (take) begin
          pend_valid_n = 1'b1;
          pend_addr_n  = WADDR;
          pend_data_n  = WDATA;
        end
        if (cnt == '0) begin
          cnt_n   = CW'(PULSE_CYCLES - 1);
          state_n = PULSE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (take) begin
          pend_valid_n = 1'b1;
          pend_addr_n  = WADDR;
          pend_data_n  = WDATA;
        end
        if (cnt == '0) state_n = HOLD;
        else           cnt_n   = cnt - 1'b1;
      end
      HOLD: begin
        // READY is low whenever pending is valid, so a HOLD-cycle accept can
        // only occur with pending empty and is loaded straight into active.
        if (pend_valid) begin
          act_addr_n   = pend_addr;
          act_data_n   = pend_data;
          pend_valid_n = 1'b0;
          cnt_n        = CW'(SETUP_CYCLES - 1);
          state_n      = SETUP;
        end else if (take) begin
          act_addr_n = WADDR;
          act_data_n = WDATA;
          cnt_n      = CW'(SETUP_CYCLES - 1);
          state_n    = SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered bus and enable outputs
  always_comb begin
    d_n   = (state_n != IDLE) ? act_data_n : D;
    wen_n = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      wen_n[i] = (state_n == PULSE) && ({1'b0, act_addr_n} == (AW+1)'(i));
    end
  end

`ifdef WRITE_FORWARD_EN
  // Forwarding lookup; pending is younger and takes priority
  always_comb begin
    FWD_HIT  = 1'b0;
    FWD_DATA = '0;
    if (FWD_RADDR != '0) begin
      if (pend_valid && (pend_addr == FWD_RADDR)) begin
        FWD_HIT  = 1'b1;
        FWD_DATA = pend_data;
      end else if ((state != IDLE) && (act_addr == FWD_RADDR)) begin
        FWD_HIT  = 1'b1;
        FWD_DATA = act_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Self-checking bench for regfile_write_sequencer.
// u0: 6-bit address so out-of-range indices can be offered, 1/1 timing.
// u1: SETUP_CYCLES=2, PULSE_CYCLES=3 for the reset-mid-pulse scenario.
`timescale 1ns/1ps
module tb_regfile_write_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst0, we0, ready0, busy0;
  logic [5:0]  waddr0;
  logic [31:0] wdata0, d0, wen0, nwen0;
  logic        rst1, we1, ready1, busy1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1, d1, wen1, nwen1;
`ifdef WRITE_FORWARD_EN
  logic [5:0]  fwd_raddr0;
  logic        fwd_hit0;
  logic [31:0] fwd_data0;
  logic [4:0]  fwd_raddr1;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
`endif

  regfile_write_sequencer #(.NREGS(32), .AW(6), .XLEN(32), .SETUP_CYCLES(1), .PULSE_CYCLES(1)) u0 (
    .CLK(CLK), .RST(rst0), .WE(we0), .WADDR(waddr0), .WDATA(wdata0),
    .READY(ready0), .BUSY(busy0), .D(d0), .WEN(wen0), .nWEN(nwen0)
`ifdef WRITE_FORWARD_EN
    , .FWD_RADDR(fwd_raddr0), .FWD_HIT(fwd_hit0), .FWD_DATA(fwd_data0)
`endif
  );

  regfile_write_sequencer #(.NREGS(32), .AW(5), .XLEN(32), .SETUP_CYCLES(2), .PULSE_CYCLES(3)) u1 (
    .CLK(CLK), .RST(rst1), .WE(we1), .WADDR(waddr1), .WDATA(wdata1),
    .READY(ready1), .BUSY(busy1), .D(d1), .WEN(wen1), .nWEN(nwen1)
`ifdef WRITE_FORWARD_EN
    , .FWD_RADDR(fwd_raddr1), .FWD_HIT(fwd_hit1), .FWD_DATA(fwd_data1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  bit          mon_en = 1'b0;
  logic [31:0] prev_wen0 = '0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive0(input logic we, input logic [5:0] a, input logic [31:0] dat);
    we0 = we; waddr0 = a; wdata0 = dat;
  endtask

  // Invariants on both instances, and scoreboard pops on each new u0 pulse
  always @(negedge CLK) begin
    wr_t e;
    if (mon_en) begin
      n_checks++;
      if (nwen0 !== ~wen0) begin n_fail++; $display("FAIL inv_nwen0: nWEN=%h required %h", nwen0, ~wen0); end
      n_checks++;
      if (!$onehot0(wen0)) begin n_fail++; $display("FAIL onehot0: WEN=%h required at most one bit", wen0); end
      n_checks++;
      if (nwen1 !== ~wen1) begin n_fail++; $display("FAIL inv_nwen1: nWEN=%h required %h", nwen1, ~wen1); end
      if (wen0 !== '0 && prev_wen0 === '0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL unexpected_pulse: WEN=%h required 00000000", wen0);
        end else begin
          e = sb.pop_front();
          if (wen0 !== (32'd1 << e.addr)) begin n_fail++; $display("FAIL pulse_row: WEN=%h required %h", wen0, 32'd1 << e.addr); end
          n_checks++;
          if (d0 !== e.data) begin n_fail++; $display("FAIL pulse_data: D=%h required %h", d0, e.data); end
        end
      end
      prev_wen0 = wen0;
    end
  end

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    drive0(1'b0, '0, '0);
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    tick();
    mon_en = 1'b1;
    tick(); tick();
    n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL rst_ready: READY=%b required 0", ready0); end
    n_checks++; if (wen0 !== '0) begin n_fail++; $display("FAIL rst_wen: WEN=%h required 00000000", wen0); end
    n_checks++; if (nwen0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_nwen: nWEN=%h required ffffffff", nwen0); end
    n_checks++; if (d0 !== '0) begin n_fail++; $display("FAIL rst_d: D=%h required 00000000", d0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: BUSY=%b required 0", busy0); end
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: READY=%b required 1", ready0); end
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready1: READY=%b required 1", ready1); end
    tick();
  endtask

  task automatic test_single_write();
    n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL single_ready: READY=%b required 1", ready0); end
    drive0(1'b1, 6'd5, 32'hDEAD_BEEF);
    sb.push_back('{addr: 6'd5, data: 32'hDEAD_BEEF});
    tick();
    drive0(1'b0, '0, '0);
    n_checks++; if (d0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_setup_d: D=%h required deadbeef", d0); end
    n_checks++; if (wen0 !== '0) begin n_fail++; $display("FAIL single_setup_wen: WEN=%h required 00000000", wen0); end
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL single_setup_busy: BUSY=%b required 1", busy0); end
    tick();
    n_checks++; if (wen0 !== 32'h0000_0020) begin n_fail++; $display("FAIL single_pulse_wen: WEN=%h required 00000020", wen0); end
    tick();
    n_checks++; if (wen0 !== '0) begin n_fail++; $display("FAIL single_hold_wen: WEN=%h required 00000000", wen0); end
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL single_hold_busy: BUSY=%b required 1", busy0); end
    tick();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: BUSY=%b required 0", busy0); end
    n_checks++; if (d0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_idle_d: D=%h required deadbeef", d0); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  addrs [3];
    logic [31:0] datas [3];
    logic [31:0] exp_wen;
    logic        exp_rdy;
    int          idx;
    logic        acc;
    addrs[0] = 6'd3; addrs[1] = 6'd7; addrs[2] = 6'd9;
    datas[0] = 32'h11; datas[1] = 32'h22; datas[2] = 32'h33;
    idx = 0;
    for (int k = 0; k <= 10; k++) begin
      exp_wen = (k == 2) ? 32'd1 << 3 : (k == 5) ? 32'd1 << 7 : (k == 8) ? 32'd1 << 9 : 32'd0;
      n_checks++;
      if (wen0 !== exp_wen) begin n_fail++; $display("FAIL b2b_wen[%0d]: WEN=%h required %h", k, wen0, exp_wen); end
      acc = 1'b0;
      if (idx < 3) begin
        exp_rdy = (k != 2) && (k != 3);
        n_checks++;
        if (ready0 !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready[%0d]: READY=%b required %b", k, ready0, exp_rdy); end
        drive0(1'b1, addrs[idx], datas[idx]);
        acc = ready0;
        if (acc) sb.push_back('{addr: addrs[idx], data: datas[idx]});
      end else begin
        drive0(1'b0, '0, '0);
      end
      tick();
      if (acc) idx++;
    end
    n_checks++; if (idx != 3) begin n_fail++; $display("FAIL b2b_accepts: accepted %0d required 3", idx); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: BUSY=%b required 0", busy0); end
  endtask

  task automatic test_discard();
    n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL disc_ready0: READY=%b required 1", ready0); end
    drive0(1'b1, 6'd0, 32'hBAD0);
    tick();
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL disc_busy0: BUSY=%b required 0", busy0); end
    n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL disc_ready40: READY=%b required 1", ready0); end
    drive0(1'b1, 6'd40, 32'hBAD1);
    tick();
    drive0(1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL disc_busy[%0d]: BUSY=%b required 0", k, busy0); end
      n_checks++; if (wen0 !== '0) begin n_fail++; $display("FAIL disc_wen[%0d]: WEN=%h required 00000000", k, wen0); end
      tick();
    end
  endtask

  task automatic test_repeat_addr();
    logic [31:0] vals [2];
    bit done;
    vals[0] = 32'hA1; vals[1] = 32'hA2;
    for (int w = 0; w < 2; w++) begin
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        drive0(1'b1, 6'd12, vals[w]);
        if (ready0 === 1'b1) begin
          sb.push_back('{addr: 6'd12, data: vals[w]});
          done = 1'b1;
        end
        tick();
      end
      n_checks++;
      if (!done) begin n_fail++; $display("FAIL repeat_timeout[%0d]: accepted 0 required 1", w); end
    end
    drive0(1'b0, '0, '0);
    repeat (8) tick();
    n_checks++; if (d0 !== 32'hA2) begin n_fail++; $display("FAIL repeat_last_d: D=%h required 000000a2", d0); end
  endtask

  task automatic test_reset_mid_pulse();
    we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h55;
    tick();
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL rmp_ready: READY=%b required 1", ready1); end
    waddr1 = 5'd11; wdata1 = 32'h66;
    tick();
    we1 = 1'b0;
    n_checks++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL rmp_pending: READY=%b required 0", ready1); end
    tick();
    n_checks++; if (wen1 !== (32'd1 << 10)) begin n_fail++; $display("FAIL rmp_pulse1: WEN=%h required %h", wen1, 32'd1 << 10); end
    tick();
    n_checks++; if (wen1 !== (32'd1 << 10)) begin n_fail++; $display("FAIL rmp_pulse2: WEN=%h required %h", wen1, 32'd1 << 10); end
    rst1 = 1'b1;
    tick();
    n_checks++; if (wen1 !== '0) begin n_fail++; $display("FAIL rmp_wen: WEN=%h required 00000000", wen1); end
    n_checks++; if (nwen1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rmp_nwen: nWEN=%h required ffffffff", nwen1); end
    n_checks++; if (d1 !== '0) begin n_fail++; $display("FAIL rmp_d: D=%h required 00000000", d1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rmp_busy: BUSY=%b required 0", busy1); end
    n_checks++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL rmp_ready_rst: READY=%b required 0", ready1); end
    rst1 = 1'b0;
    #1;
    n_checks++; if (ready1 !== 1'b1) begin n_fail++; $display("FAIL rmp_ready_after: READY=%b required 1", ready1); end
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++; if (wen1 !== '0) begin n_fail++; $display("FAIL rmp_no_resume[%0d]: WEN=%h required 00000000", k, wen1); end
    end
  endtask

`ifdef WRITE_FORWARD_EN
  task automatic test_forward();
    n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL fwd_ready: READY=%b required 1", ready0); end
    drive0(1'b1, 6'd4, 32'hAA);
    sb.push_back('{addr: 6'd4, data: 32'hAA});
    tick();
    n_checks++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL fwd_ready2: READY=%b required 1", ready0); end
    drive0(1'b1, 6'd4, 32'hBB);
    sb.push_back('{addr: 6'd4, data: 32'hBB});
    tick();
    drive0(1'b0, '0, '0);
    fwd_raddr0 = 6'd4; #1;
    n_checks++; if (fwd_hit0 !== 1'b1) begin n_fail++; $display("FAIL fwd_hit: HIT=%b required 1", fwd_hit0); end
    n_checks++; if (fwd_data0 !== 32'hBB) begin n_fail++; $display("FAIL fwd_data: DATA=%h required 000000bb", fwd_data0); end
    fwd_raddr0 = 6'd0; #1;
    n_checks++; if (fwd_hit0 !== 1'b0) begin n_fail++; $display("FAIL fwd_r0_hit: HIT=%b required 0", fwd_hit0); end
    n_checks++; if (fwd_data0 !== '0) begin n_fail++; $display("FAIL fwd_r0_data: DATA=%h required 00000000", fwd_data0); end
    fwd_raddr0 = 6'd5; #1;
    n_checks++; if (fwd_hit0 !== 1'b0) begin n_fail++; $display("FAIL fwd_miss: HIT=%b required 0", fwd_hit0); end
    tick(); tick();
    fwd_raddr0 = 6'd4; #1;
    n_checks++; if (fwd_hit0 !== 1'b1) begin n_fail++; $display("FAIL fwd_active_hit: HIT=%b required 1", fwd_hit0); end
    n_checks++; if (fwd_data0 !== 32'hBB) begin n_fail++; $display("FAIL fwd_active_data: DATA=%h required 000000bb", fwd_data0); end
    fwd_raddr0 = 6'd0;
    repeat (6) tick();
  endtask
`endif

  initial begin
`ifdef WRITE_FORWARD_EN
    fwd_raddr0 = '0;
    fwd_raddr1 = '0;
`endif
    test_reset();
    test_single_write();
    test_back_to_back();
    test_discard();
    test_repeat_addr();
    test_reset_mid_pulse();
`ifdef WRITE_FORWARD_EN
    test_forward();
`endif
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d writes outstanding required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
